rom_load_sequencer: RTL and testbench
=====================================

// Module: rom_load_sequencer
// PURPOSE
//  Sequences loading of the 16K x 16-bit cartridge program ROM from the APF bridge.
//  Accepts 32-bit bridge words and splits each into two 16-bit ROM writes on consecutive
//  cycles, with optional byte swap. Drops halfwords beyond ROM depth and reports load status.
//  Sits between the bridge data-slot logic and the ROM write port (same clock domain as the write port).
// PARAMETERS
//  ADDR_WIDTH  14     ROM halfword address width
//  ROM_WORDS   16384  halfwords actually present; halfword index >= ROM_WORDS is dropped
//  SWAP_BYTES  1      1: swap the two bytes within each halfword before writing
// PORTS
//  clk             in   1           single clock; all logic on posedge
//  reset           in   1           asynchronous, active-high
//  load_start      in   1           pulse: clear done/overflow/words_written
//  load_end        in   1           pulse: bridge finished sending; done raised once drained
//  in_valid        in   1           bridge word valid
//  in_ready        out  1           sequencer can accept a word this cycle
//  in_addr         in   16          32-bit word index within the ROM image
//  in_data         in   32          big-endian image data; [31:16] = first halfword
//  rom_write_en    out  1           ROM write strobe
//  rom_write_addr  out  ADDR_WIDTH  ROM halfword address
//  rom_write_data  out  16          ROM halfword data
//  busy            out  1           high while FSM is not IDLE
//  done            out  1           sticky load complete
//  overflow        out  1           sticky: at least one halfword was dropped
//  words_written   out  16          count of halfwords actually written (saturates at 16'hFFFF)
// BEHAVIOUR
//  Reset: FSM=IDLE; in_ready=1, rom_write_en=0, rom_write_addr=0, rom_write_data=0,
//   busy=0, done=0, overflow=0, words_written=0, end_pending=0. Reset mid-pair abandons it.
//  Accept: transfer occurs on cycle where in_valid && in_ready; in_addr/in_data latched.
//  in_ready = (state==IDLE) || (state==WR_HI); no combinational path from in_valid to in_ready.
//  FSM: IDLE --accept--> WR_LO --> WR_HI --accept--> WR_LO | --no accept--> IDLE.
//  WR_LO: halfword index h0 = {in_addr,1'b0}, data = latched[31:16].
//  WR_HI: h1 = {in_addr,1'b1}, data = latched[15:0].
//  SWAP_BYTES=1: data = {d[7:0], d[15:8]} applied per halfword.
//  rom_write_en/addr/data registered: asserted in the cycle state is WR_LO/WR_HI
//   (first write one cycle after accept); sustained throughput 1 word / 2 cycles.
//  Bound: if h >= ROM_WORDS, rom_write_en=0 that cycle, overflow<=1, count unchanged;
//   the other halfword of the pair is still written if in range. Address = h[ADDR_WIDTH-1:0].
//  words_written += 1 per asserted rom_write_en, saturating.
//  load_end: sets end_pending. done <= 1 on the first cycle where end_pending && state==IDLE
//   (immediately next cycle if already IDLE with no accept); end_pending cleared then.
//  load_end coincident with accept: the accepted word is written before done rises.
//  load_start: clears done, overflow, words_written, end_pending next cycle; does NOT abort
//   an in-flight pair (its writes still count after the clear). load_start and load_end in the same
//   cycle: clear wins, then end_pending=1.
//  busy = (state != IDLE).
// TESTING
//  1 Reset, accept {addr=0,data=32'h1122_3344}, SWAP=1 -> wr @0=16'h2211, next cycle @1=16'h4433, count=2.
//  2 Back-to-back valid for addr 0..3 -> in_ready low only in WR_LO; 8 writes on 8 consecutive cycles.
//  3 ROM_WORDS=16384, addr=16'h2000 -> no write_en for h=16384/16385, overflow=1, count unchanged.
//  4 load_end pulsed with accept -> done rises the cycle after WR_HI returns to IDLE, not earlier.
//  5 load_start while in WR_LO -> WR_HI write still issued; done=0, overflow=0, count=1 afterwards.
//  6 Assert reset during WR_LO -> outputs at reset values immediately (async), no WR_HI write after release.

Source files
------------

// File: rtl/rom_load_sequencer.sv
// Cartridge ROM load sequencer: splits 32-bit bridge words into two
// 16-bit ROM writes, drops out-of-range halfwords and tracks load status.
module rom_load_sequencer #(
  parameter int ADDR_WIDTH = 14,
  parameter int ROM_WORDS  = 16384,
  parameter bit SWAP_BYTES = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_end,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_addr,
  input  logic [31:0]           in_data,
  output logic                  rom_write_en,
  output logic [ADDR_WIDTH-1:0] rom_write_addr,
  output logic [15:0]           rom_write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [15:0]           words_written
);

  typedef enum logic [1:0] {
    IDLE,
    WR_LO,
    WR_HI
  } state_t;

  state_t                state_q;
  logic [15:0]           addr_q;
  logic [15:0]           lo_q;
  logic                  wen_q;
  logic                  drop_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [15:0]           wdata_q;
  logic                  done_q;
  logic                  ovf_q;
  logic                  pend_q;
  logic [15:0]           cnt_q;

  logic                  accept;
  logic                  wr_d;
  logic [16:0]           h_d;
  logic [15:0]           hw_d;
  logic                  end_eff;

  function automatic logic [15:0] swap(
    input logic [15:0] d
  );
    return SWAP_BYTES ? {d[7:0], d[15:8]} : d;
  endfunction

  function automatic logic in_rng(
    input logic [16:0] h
  );
    return {15'd0, h} < $unsigned(ROM_WORDS);
  endfunction

  assign in_ready = (state_q == IDLE) ||
                    (state_q == WR_HI);
  assign accept   = in_valid && in_ready;
  assign end_eff  = pend_q || load_end;

  // Pick the halfword that will be on the write port next cycle.
  always_comb begin
    wr_d = 1'b0;
    h_d  = {in_addr, 1'b0};
    hw_d = in_data[31:16];
    if (state_q == WR_LO) begin
      wr_d = 1'b1;
      h_d  = {addr_q, 1'b1};
      hw_d = lo_q;
    end else if (accept) begin
      wr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lo_q    <= '0;
      wen_q   <= 1'b0;
      drop_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wen_q  <= wr_d && in_rng(h_d);
      drop_q <= wr_d && !in_rng(h_d);
      if (wr_d) begin
        waddr_q <= h_d[ADDR_WIDTH-1:0];
        wdata_q <= swap(hw_d);
      end
      if (accept) begin
        addr_q <= in_addr;
        lo_q   <= in_data[15:0];
      end

      unique case (state_q)
        IDLE:    if (accept) state_q <= WR_LO;
        WR_LO:   state_q <= WR_HI;
        WR_HI:   state_q <= accept ? WR_LO : IDLE;
        default: state_q <= IDLE;
      endcase

      // A start pulse wins over anything completing this cycle.
      if (load_start) begin
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
        cnt_q  <= '0;
        pend_q <= load_end;
      end else begin
        if (drop_q) ovf_q <= 1'b1;
        if (wen_q && cnt_q != 16'hFFFF)
          cnt_q <= cnt_q + 16'd1;
        if (end_eff && state_q == IDLE &&
            !accept) begin
          done_q <= 1'b1;
          pend_q <= 1'b0;
        end else if (load_end) begin
          pend_q <= 1'b1;
        end
      end
    end
  end

  assign rom_write_en   = wen_q;
  assign rom_write_addr = waddr_q;
  assign rom_write_data = wdata_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign overflow       = ovf_q;
  assign words_written  = cnt_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Bench for rom_load_sequencer: vector table, directed corner
// sequences and a randomized run against a queue-based model.
module tb_rom_load_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        load_end;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_addr;
  logic [31:0] in_data;
  logic        rom_write_en;
  logic [13:0] rom_write_addr;
  logic [15:0] rom_write_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] words_written;

  int checks   = 0;
  int failures = 0;

  rom_load_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .load_start    (load_start),
    .load_end      (load_end),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .rom_write_en  (rom_write_en),
    .rom_write_addr(rom_write_addr),
    .rom_write_data(rom_write_data),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic        en0;
    logic [13:0] a0;
    logic [15:0] d0;
    logic        en1;
    logic [13:0] a1;
    logic [15:0] d1;
    logic [15:0] cnt;
    logic        ovf;
  } vec_t;

  typedef struct packed {
    logic [16:0] h;
    logic [15:0] d;
    logic        lo;
  } hw_t;

  vec_t tbl[6];

  // reference model state
  hw_t         q[$];
  logic        m_ready, m_busy, m_wen, m_drop;
  logic [13:0] m_waddr;
  logic [15:0] m_wdata;
  logic        m_done, m_ovf, m_pend;
  logic [15:0] m_cnt;

  function automatic logic [15:0] sw(
    input logic [15:0] d
  );
    return {d[7:0], d[15:8]};
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid   = 1'b0;
    load_start = 1'b0;
    load_end   = 1'b0;
  endtask

  task automatic m_init();
    q.delete();
    m_ready = 1'b1;
    m_busy  = 1'b0;
    m_wen   = 1'b0;
    m_drop  = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_done  = 1'b0;
    m_ovf   = 1'b0;
    m_pend  = 1'b0;
    m_cnt   = '0;
  endtask

  task automatic m_step();
    logic acc;
    logic idle;
    hw_t  e;
    acc  = in_valid && m_ready;
    idle = !m_busy;
    if (load_start) begin
      m_done = 1'b0;
      m_ovf  = 1'b0;
      m_cnt  = '0;
      m_pend = load_end;
    end else begin
      if (m_drop) m_ovf = 1'b1;
      if (m_wen && m_cnt != 16'hFFFF)
        m_cnt = m_cnt + 16'd1;
      if ((m_pend || load_end) && idle && !acc) begin
        m_done = 1'b1;
        m_pend = 1'b0;
      end else if (load_end) begin
        m_pend = 1'b1;
      end
    end
    if (acc) begin
      q.push_back({in_addr, 1'b0, in_data[31:16], 1'b1});
      q.push_back({in_addr, 1'b1, in_data[15:0], 1'b0});
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      m_busy  = 1'b1;
      m_ready = !e.lo;
      m_wen   = (e.h < 17'd16384);
      m_drop  = !m_wen;
      m_waddr = e.h[13:0];
      m_wdata = sw(e.d);
    end else begin
      m_busy  = 1'b0;
      m_ready = 1'b1;
      m_wen   = 1'b0;
      m_drop  = 1'b0;
    end
  endtask

  task automatic m_compare();
    chk("rnd_ready", 32'(in_ready), 32'(m_ready));
    chk("rnd_busy", 32'(busy), 32'(m_busy));
    chk("rnd_en", 32'(rom_write_en), 32'(m_wen));
    if (m_wen) begin
      chk("rnd_addr", 32'(rom_write_addr), 32'(m_waddr));
      chk("rnd_data", 32'(rom_write_data), 32'(m_wdata));
    end
    chk("rnd_done", 32'(done), 32'(m_done));
    chk("rnd_ovf", 32'(overflow), 32'(m_ovf));
    chk("rnd_cnt", 32'(words_written), 32'(m_cnt));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    in_addr = '0;
    in_data = '0;
    repeat (2) tick();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_en", 32'(rom_write_en), 32'd0);
    chk("rst_addr", 32'(rom_write_addr), 32'd0);
    chk("rst_data", 32'(rom_write_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_cnt", 32'(words_written), 32'd0);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int word;
    logic acc;
    int r;

    tbl[0] = '{16'h0000, 32'h1122_3344,
               1, 14'h0000, 16'h2211,
               1, 14'h0001, 16'h4433, 16'd2, 0};
    tbl[1] = '{16'h0005, 32'hA1B2_C3D4,
               1, 14'h000A, 16'hB2A1,
               1, 14'h000B, 16'hD4C3, 16'd4, 0};
    tbl[2] = '{16'h1FFF, 32'h0000_FFFF,
               1, 14'h3FFE, 16'h0000,
               1, 14'h3FFF, 16'hFFFF, 16'd6, 0};
    tbl[3] = '{16'h2000, 32'hDEAD_BEEF,
               0, 14'h0000, 16'h0000,
               0, 14'h0000, 16'h0000, 16'd6, 1};
    tbl[4] = '{16'h1234, 32'h00FF_0F0F,
               1, 14'h2468, 16'hFF00,
               1, 14'h2469, 16'h0F0F, 16'd8, 1};
    tbl[5] = '{16'hFFFF, 32'h1234_5678,
               0, 14'h0000, 16'h0000,
               0, 14'h0000, 16'h0000, 16'd8, 1};

    do_reset();

    // isolated words from the vector table
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_addr  = tbl[i].addr;
      in_data  = tbl[i].data;
      tick();
      in_valid = 1'b0;
      chk("tbl_en0", 32'(rom_write_en), 32'(tbl[i].en0));
      if (tbl[i].en0) begin
        chk("tbl_a0", 32'(rom_write_addr), 32'(tbl[i].a0));
        chk("tbl_d0", 32'(rom_write_data), 32'(tbl[i].d0));
      end
      chk("tbl_rdy_lo", 32'(in_ready), 32'd0);
      chk("tbl_busy", 32'(busy), 32'd1);
      tick();
      chk("tbl_en1", 32'(rom_write_en), 32'(tbl[i].en1));
      if (tbl[i].en1) begin
        chk("tbl_a1", 32'(rom_write_addr), 32'(tbl[i].a1));
        chk("tbl_d1", 32'(rom_write_data), 32'(tbl[i].d1));
      end
      chk("tbl_rdy_hi", 32'(in_ready), 32'd1);
      tick();
      chk("tbl_idle", 32'(busy), 32'd0);
      chk("tbl_cnt", 32'(words_written), 32'(tbl[i].cnt));
      chk("tbl_ovf", 32'(overflow), 32'(tbl[i].ovf));
      chk("tbl_done", 32'(done), 32'd0);
    end

    // load_end together with an accept
    in_valid = 1'b1;
    in_addr  = 16'h0003;
    in_data  = 32'h0102_0304;
    load_end = 1'b1;
    tick();
    idle_in();
    chk("le_lo_done", 32'(done), 32'd0);
    tick();
    chk("le_hi_done", 32'(done), 32'd0);
    chk("le_hi_addr", 32'(rom_write_addr), 32'd7);
    tick();
    chk("le_idle_done", 32'(done), 32'd0);
    chk("le_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("le_done", 32'(done), 32'd1);
    chk("le_cnt", 32'(words_written), 32'd10);

    // clear, then load_end while idle
    load_start = 1'b1;
    tick();
    idle_in();
    chk("ls_done", 32'(done), 32'd0);
    chk("ls_ovf", 32'(overflow), 32'd0);
    chk("ls_cnt", 32'(words_written), 32'd0);
    load_end = 1'b1;
    tick();
    idle_in();
    chk("le_idle_fast", 32'(done), 32'd1);
    load_start = 1'b1;
    load_end   = 1'b1;
    tick();
    idle_in();
    chk("lsle_clr", 32'(done), 32'd0);
    tick();
    chk("lsle_done", 32'(done), 32'd1);

    // dropped word sets overflow
    in_valid = 1'b1;
    in_addr  = 16'h2000;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_cnt", 32'(words_written), 32'd0);

    // load_start during the low write
    in_valid = 1'b1;
    in_addr  = 16'h0007;
    in_data  = 32'hAABB_CCDD;
    tick();
    in_valid   = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("mid_en", 32'(rom_write_en), 32'd1);
    chk("mid_addr", 32'(rom_write_addr), 32'd15);
    chk("mid_data", 32'(rom_write_data), 32'hDDCC);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_ovf", 32'(overflow), 32'd0);
    chk("mid_cnt0", 32'(words_written), 32'd0);
    tick();
    chk("mid_cnt1", 32'(words_written), 32'd1);
    chk("mid_done2", 32'(done), 32'd0);
    chk("mid_ovf2", 32'(overflow), 32'd0);

    // async reset in the middle of a pair
    in_valid = 1'b1;
    in_addr  = 16'h0002;
    in_data  = 32'h5566_7788;
    tick();
    in_valid = 1'b0;
    chk("ar_pre_en", 32'(rom_write_en), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_en", 32'(rom_write_en), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_addr", 32'(rom_write_addr), 32'd0);
    chk("ar_data", 32'(rom_write_data), 32'd0);
    chk("ar_cnt", 32'(words_written), 32'd0);
    chk("ar_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_post_en", 32'(rom_write_en), 32'd0);
      chk("ar_post_busy", 32'(busy), 32'd0);
    end

    // back-to-back stream of four words
    word     = 0;
    in_valid = 1'b1;
    in_addr  = 16'h0000;
    in_data  = 32'h0000_0000;
    for (int c = 1; c <= 8; c++) begin
      acc = in_ready && in_valid;
      tick();
      if (acc) begin
        word++;
        in_addr  = 16'(word);
        in_data  = {16'(word), 16'(word)};
        in_valid = (word < 4);
      end
      chk("b2b_en", 32'(rom_write_en), 32'd1);
      chk("b2b_addr", 32'(rom_write_addr), 32'(c - 1));
      chk("b2b_ready", 32'(in_ready), 32'((c % 2) == 0));
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_idle", 32'(busy), 32'd0);
    chk("b2b_cnt", 32'(words_written), 32'd8);

    // randomized run against the model
    do_reset();
    m_init();
    for (int n = 0; n < 3000; n++) begin
      m_compare();
      in_valid   = ($urandom_range(0, 9) < 7);
      load_start = ($urandom_range(0, 49) == 0);
      load_end   = ($urandom_range(0, 29) == 0);
      r = int'($urandom_range(0, 3));
      if (r == 0)
        in_addr = 16'h1FFE + 16'($urandom_range(0, 3));
      else if (r == 1)
        in_addr = 16'($urandom);
      else
        in_addr = 16'($urandom_range(0, 16'h1FFF));
      in_data = $urandom;
      m_step();
      tick();
    end
    idle_in();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
